pipe_debug_sequencer: RTL and testbench

Command sequencer between `uart_rx`, the char FIFO feeding `uart_tx`, and the `Pipeline` core. It decodes single-byte host commands and steps or free-runs the pipeline through a clock-enable (no gated clock). After each step or halt it streams a snapshot of selected 32-bit pipeline words, plus a cycle counter, into the TX FIFO, one byte at a time and LSB first.

---
 rtl/debug_pkg.sv | 32 +++
 rtl/byte_serializer.sv | 42 ++++
 rtl/pipe_debug_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pipe_debug_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared types and constants for the pipeline debug sequencer.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_STEP = 3'd1,
        ST_RUN  = 3'd2,
        ST_LOAD = 3'd3,
        ST_BYTE = 3'd4,
        ST_ERR  = 3'd5
    } seq_state_t;

    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'
    localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D'
    localparam logic [7:0] ERR_BYTE = 8'h3F;  // '?'

    // Next state for a command byte received while idle. HALT is only
    // meaningful in RUN, so from IDLE it is an unknown command.
    function automatic seq_state_t idle_cmd_decode(input logic [7:0] cmd);
        seq_state_t nxt;
        case (cmd)
            CMD_STEP: nxt = ST_STEP;
            CMD_RUN:  nxt = ST_RUN;
            CMD_DUMP: nxt = ST_LOAD;
            default:  nxt = ST_ERR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/byte_serializer.sv
// Splits a 32-bit word into four bytes, LSB first, pushed into a FIFO
// that may apply backpressure. done pulses with the fourth push.
module byte_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        en,
    input  logic        fifo_full,
    output logic [7:0]  byte_out,
    output logic        wr_en,
    output logic        done
);

    logic [31:0] shreg_r;
    logic [1:0]  cnt_r;
    logic        wr_s;

    // A push happens only while enabled and the FIFO has room.
    always_comb begin
        wr_s = en & ~fifo_full;
    end

    // Shift register and byte counter; both hold while backpressured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= 32'd0;
            cnt_r   <= 2'd0;
        end else if (load) begin
            shreg_r <= load_data;
            cnt_r   <= 2'd0;
        end else if (wr_s) begin
            shreg_r <= {8'd0, shreg_r[31:8]};
            cnt_r   <= cnt_r + 2'd1;
        end
    end

    assign byte_out = shreg_r[7:0];
    assign wr_en    = wr_s;
    assign done     = wr_s & (cnt_r == 2'd3);

endmodule

// File: rtl/pipe_debug_sequencer.sv
// Host command sequencer: steps or free-runs the pipeline via a clock
// enable and streams a snapshot of pipeline words plus a cycle count
// into the UART TX FIFO.
module pipe_debug_sequencer
    import debug_pkg::*;
#(
    parameter int NUM_WORDS = 4,
    parameter int WSEL_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_rdy,
    input  logic              fifo_full,
    output logic [7:0]        fifo_din,
    output logic              fifo_wr_en,
    output logic              pipe_en,
    output logic [WSEL_W-1:0] word_sel,
    input  logic [31:0]       dump_word,
    output logic              busy,
    output logic [31:0]       cycle_count
);

    // Index runs 0..NUM_WORDS; NUM_WORDS selects the cycle counter.
    localparam int IDX_W = $clog2(NUM_WORDS + 1);

    seq_state_t       state_r, state_nxt_s;
    logic             rx_rdy_q_r;
    logic [IDX_W-1:0] idx_r, idx_nxt_s;
    logic             load_ph_r, load_ph_nxt_s;
    logic [31:0]      cycle_count_r;
    logic             cmd_evt_s;
    logic             pipe_en_s;
    logic             ser_load_s;
    logic             ser_en_s;
    logic [31:0]      ser_data_s;
    logic [7:0]       ser_byte_s;
    logic             ser_wr_s;
    logic             ser_done_s;
    logic             last_word_s;

    assign cmd_evt_s   = rx_data_rdy & ~rx_rdy_q_r;
    assign last_word_s = (idx_r == IDX_W'(NUM_WORDS));
    assign ser_data_s  = last_word_s ? cycle_count_r : dump_word;

    // Receive-strobe delay for rising-edge command detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rdy_q_r <= 1'b0;
        end else begin
            rx_rdy_q_r <= rx_data_rdy;
        end
    end

    // Sequencer state, word index and LOAD phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            load_ph_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            load_ph_r <= load_ph_nxt_s;
        end
    end

    // Pipeline cycle counter; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_r <= 32'd0;
        end else if (pipe_en_s) begin
            cycle_count_r <= cycle_count_r + 32'd1;
        end
    end

    // Next-state and control decode. Commands outside IDLE/RUN are dropped.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        load_ph_nxt_s = load_ph_r;
        pipe_en_s     = 1'b0;
        ser_load_s    = 1'b0;
        ser_en_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_evt_s) begin
                    state_nxt_s   = idle_cmd_decode(rx_data);
                    idx_nxt_s     = '0;
                    load_ph_nxt_s = 1'b0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_STEP: begin
                pipe_en_s     = 1'b1;
                state_nxt_s   = ST_LOAD;
                idx_nxt_s     = '0;
                load_ph_nxt_s = 1'b0;
            end
            ST_RUN: begin
                // The halt cycle itself still advances the pipeline.
                pipe_en_s = 1'b1;
                if (cmd_evt_s && (rx_data == CMD_HALT)) begin
                    state_nxt_s   = ST_LOAD;
                    idx_nxt_s     = '0;
                    load_ph_nxt_s = 1'b0;
                end else begin
                    state_nxt_s   = ST_RUN;
                end
            end
            ST_LOAD: begin
                // Phase 0 lets the external mux settle on word_sel.
                if (!load_ph_r) begin
                    load_ph_nxt_s = 1'b1;
                end else begin
                    ser_load_s    = 1'b1;
                    load_ph_nxt_s = 1'b0;
                    state_nxt_s   = ST_BYTE;
                end
            end
            ST_BYTE: begin
                ser_en_s = 1'b1;
                if (ser_done_s) begin
                    if (last_word_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        idx_nxt_s     = idx_r + IDX_W'(1);
                        load_ph_nxt_s = 1'b0;
                        state_nxt_s   = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_BYTE;
                end
            end
            ST_ERR: begin
                if (!fifo_full) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                idx_nxt_s     = '0;
                load_ph_nxt_s = 1'b0;
            end
        endcase
    end

    byte_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load_s),
        .load_data (ser_data_s),
        .en        (ser_en_s),
        .fifo_full (fifo_full),
        .byte_out  (ser_byte_s),
        .wr_en     (ser_wr_s),
        .done      (ser_done_s)
    );

    assign fifo_wr_en  = (state_r == ST_ERR) ? ~fifo_full : ser_wr_s;
    assign fifo_din    = (state_r == ST_ERR) ? ERR_BYTE : ser_byte_s;
    assign pipe_en     = pipe_en_s;
    assign word_sel    = WSEL_W'(idx_r);
    assign busy        = (state_r != ST_IDLE);
    assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_pipe_debug_sequencer.sv
// Scoreboard bench for pipe_debug_sequencer: expected FIFO bytes are
// queued when a command is issued and checked by an independent monitor.
module tb_pipe_debug_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_data_rdy;
    logic        fifo_full;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic        pipe_en;
    logic [5:0]  word_sel;
    logic [31:0] dump_word = 32'd0;
    logic        busy;
    logic [31:0] cycle_count;

    logic [7:0]  sb_q[$];
    logic [7:0]  exp_b;
    int          total = 0;
    int          bad = 0;
    int          pe_cycles = 0;
    int          pe_rises = 0;
    logic        pe_prev = 1'b0;
    logic        word_mode = 1'b0;
    int          base_c;
    int          base_r;

    pipe_debug_sequencer #(.NUM_WORDS(4), .WSEL_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .fifo_full   (fifo_full),
        .fifo_din    (fifo_din),
        .fifo_wr_en  (fifo_wr_en),
        .pipe_en     (pipe_en),
        .word_sel    (word_sel),
        .dump_word   (dump_word),
        .busy        (busy),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // External word mux model: one cycle of latency after word_sel.
    always @(posedge clk) begin
        dump_word <= word_mode ? (32'hA0B0C0D0 + {26'd0, word_sel}) : 32'h11223344;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        sb_q.push_back(w[7:0]);
        sb_q.push_back(w[15:8]);
        sb_q.push_back(w[23:16]);
        sb_q.push_back(w[31:24]);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data     = b;
        rx_data_rdy = 1'b1;
        @(posedge clk);
        #1;
        rx_data_rdy = 1'b0;
    endtask

    // Wait for the scoreboard to empty and the DUT to go idle, bounded.
    task automatic drain(input bit toggle, input string nm);
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < 2000) begin
            @(posedge clk);
            #1;
            if (toggle) fifo_full = ~fifo_full;
            n++;
        end
        fifo_full = 1'b0;
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d left expected 0", nm, sb_q.size());
        end
        check({nm, "_left"}, sb_q.size(), 32'd0);
    endtask

    // Monitor: compare each FIFO push against the scoreboard, track pipe_en.
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %h expected none", fifo_din);
            end else begin
                exp_b = sb_q.pop_front();
                check("fifo_byte", {24'd0, fifo_din}, {24'd0, exp_b});
            end
        end
        if (pipe_en) pe_cycles++;
        if (pipe_en && !pe_prev) pe_rises++;
        pe_prev = pipe_en;
    end

    initial begin
        rst_n       = 1'b0;
        rx_data     = 8'd0;
        rx_data_rdy = 1'b0;
        fifo_full   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check("rst_din", {24'd0, fifo_din}, 32'd0);
        check("rst_pipe_en", {31'd0, pipe_en}, 32'd0);
        check("rst_word_sel", {26'd0, word_sel}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", cycle_count, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single step: one pipe_en pulse, four words then count 1.
        base_c = pe_cycles; base_r = pe_rises;
        for (int i = 0; i < 4; i++) push_word(32'h11223344);
        push_word(32'd1);
        send_cmd(8'h53);
        drain(1'b0, "step");
        check("step_pe_cycles", pe_cycles - base_c, 32'd1);
        check("step_pe_rises", pe_rises - base_r, 32'd1);
        check("step_count", cycle_count, 32'd1);

        // Run 102 cycles (R cycle+1 through H cycle inclusive), then halt.
        base_c = pe_cycles; base_r = pe_rises;
        for (int i = 0; i < 4; i++) push_word(32'h11223344);
        push_word(32'd103);
        send_cmd(8'h52);
        repeat (100) @(posedge clk);
        send_cmd(8'h48);
        drain(1'b0, "run");
        check("run_pe_cycles", pe_cycles - base_c, 32'd102);
        check("run_pe_rises", pe_rises - base_r, 32'd1);
        check("run_count", cycle_count, 32'd103);
        base_c = pe_cycles;
        repeat (10) @(posedge clk);
        #1;
        check("run_pe_after", pe_cycles - base_c, 32'd0);

        // Dump under alternating backpressure with per-index words.
        word_mode = 1'b1;
        base_c = pe_cycles;
        for (int i = 0; i < 4; i++) push_word(32'hA0B0C0D0 + i);
        push_word(32'd103);
        send_cmd(8'h44);
        drain(1'b1, "dump");
        check("dump_pe_cycles", pe_cycles - base_c, 32'd0);
        word_mode = 1'b0;

        // Unknown command: single '?' then idle.
        sb_q.push_back(8'h3F);
        send_cmd(8'h58);
        drain(1'b0, "err");
        check("err_busy", {31'd0, busy}, 32'd0);

        // Step plus a second command held high while busy: one snapshot.
        base_c = pe_cycles; base_r = pe_rises;
        for (int i = 0; i < 4; i++) push_word(32'h11223344);
        push_word(32'd104);
        send_cmd(8'h53);
        repeat (2) @(posedge clk);
        #1;
        rx_data     = 8'h53;
        rx_data_rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rx_data_rdy = 1'b0;
        drain(1'b0, "drop");
        check("drop_pe_cycles", pe_cycles - base_c, 32'd1);
        check("drop_pe_rises", pe_rises - base_r, 32'd1);
        check("drop_count", cycle_count, 32'd104);

        // Reset in the middle of a dump: outputs clear, no further writes.
        for (int i = 0; i < 4; i++) push_word(32'h11223344);
        push_word(32'd104);
        send_cmd(8'h44);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("mid_rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check("mid_rst_din", {24'd0, fifo_din}, 32'd0);
        check("mid_rst_pipe_en", {31'd0, pipe_en}, 32'd0);
        check("mid_rst_word_sel", {26'd0, word_sel}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_count", cycle_count, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Counter wrap: preset to all-ones, one step dumps zero.
        force dut.cycle_count_r = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.cycle_count_r;
        @(posedge clk);
        #1;
        check("wrap_preset", cycle_count, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) push_word(32'h11223344);
        push_word(32'd0);
        send_cmd(8'h53);
        drain(1'b0, "wrap");
        check("wrap_count", cycle_count, 32'd0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
